// File: rtl/issue_queue_param.sv
// issue_queue_param: circular multi-lane issue queue with exact occupancy, all-or-nothing enqueue and clamped dequeue
module issue_queue_param #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16,
  parameter int IN_W   = 2,
  parameter int OUT_W  = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic [IN_W*DATA_W-1:0]       in_data,
  input  logic [IN_W-1:0]              in_valid,
  output logic                         in_ready,
  output logic [OUT_W*DATA_W-1:0]      out_data,
  output logic [OUT_W-1:0]             out_valid,
  input  logic [$clog2(OUT_W+1)-1:0]   issue_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         issue_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW-1:0] wa [IN_W];
  logic [CW-1:0] n_in, n_acc, n_clamp, n_out, ic;
  logic push, bad;
  assign in_ready = count <= CW'(DEPTH - IN_W);
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign push = in_ready && |in_valid && !flush;
  assign ic = CW'(issue_cnt);
  assign bad = ic > count || ic > CW'(OUT_W);
  assign n_clamp = ic < count ? ic : count;
  assign n_out = n_clamp > CW'(OUT_W) ? CW'(OUT_W) : n_clamp;
  assign n_acc = push ? n_in : '0;
  // valid lanes are packed: each lands after the valid lanes below it
  always_comb begin
    n_in = '0;
    for (int i = 0; i < IN_W; i++) begin
      wa[i] = tail + n_in[PW-1:0];
      n_in = n_in + CW'(in_valid[i]);
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < IN_W; i++)
      if (push && in_valid[i]) mem[wa[i]] <= in_data[i*DATA_W +: DATA_W];
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      issue_err <= 1'b0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + n_out[PW-1:0];
      tail <= tail + n_acc[PW-1:0];
      count <= count + n_acc - n_out;
      if (bad) issue_err <= 1'b1;
    end
  end
  for (genvar k = 0; k < OUT_W; k++) begin : g_out
    logic [PW-1:0] ra;
    assign ra = head + PW'(k);
    assign out_valid[k] = count > CW'(k);
    assign out_data[k*DATA_W +: DATA_W] = out_valid[k] ? mem[ra] : '0;
  end
endmodule

// File: tb/tb_issue_queue_param.sv
// tb_issue_queue_param: randomized and directed bench against a queue-based reference model
module tb_issue_queue_param;
  localparam int DW = 128, D = 16, IW = 2, OW = 2;
  logic clk = 0, resetn = 0, flush = 0;
  logic [IW*DW-1:0] in_data = '0;
  logic [IW-1:0] in_valid = '0;
  logic in_ready;
  logic [OW*DW-1:0] out_data;
  logic [OW-1:0] out_valid;
  logic [1:0] issue_cnt = '0;
  logic [4:0] count;
  logic full, empty, issue_err;
  int total = 0, passed = 0;
  bit chk_en = 0;
  logic [DW-1:0] q[$];
  bit m_err = 0;
  logic [DW-1:0] a, b, c;

  issue_queue_param #(.DATA_W(DW), .DEPTH(D), .IN_W(IW), .OUT_W(OW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .issue_cnt(issue_cnt),
    .count(count), .full(full), .empty(empty), .issue_err(issue_err));

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) if (chk_en) begin
    chk("count", DW'(count), DW'(q.size()));
    chk("empty", DW'(empty), DW'(q.size() == 0));
    chk("full", DW'(full), DW'(q.size() == D));
    chk("in_ready", DW'(in_ready), DW'(D - q.size() >= IW));
    chk("issue_err", DW'(issue_err), DW'(m_err));
    for (int k = 0; k < OW; k++) begin
      chk($sformatf("out_valid%0d", k), DW'(out_valid[k]), DW'(q.size() > k));
      chk($sformatf("out_data%0d", k), out_data[k*DW +: DW], q.size() > k ? q[k] : '0);
    end
  end

  task automatic model_update();
    int n;
    bit rdy;
    if (!resetn) begin
      q.delete();
      m_err = 0;
    end else if (flush) q.delete();
    else begin
      rdy = (D - q.size()) >= IW;
      if (int'(issue_cnt) > q.size() || int'(issue_cnt) > OW) m_err = 1;
      n = int'(issue_cnt);
      if (n > q.size()) n = q.size();
      if (n > OW) n = OW;
      repeat (n) void'(q.pop_front());
      if (rdy) for (int i = 0; i < IW; i++) if (in_valid[i]) q.push_back(in_data[i*DW +: DW]);
    end
  endtask

  task automatic cyc(bit rn, bit fl, logic [1:0] iv, logic [1:0] ic);
    resetn = rn;
    flush = fl;
    in_valid = iv;
    in_data = {rnd(), rnd()};
    issue_cnt = ic;
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    cyc(0, 0, 0, 0);
    chk_en = 1;
    cyc(0, 0, 0, 0);
    chk("rst_count", DW'(count), 0);
    chk("rst_ready", DW'(in_ready), 1);
    chk("rst_valid", DW'(out_valid), 0);
    chk("rst_data", out_data[DW-1:0], 0);
    cyc(1, 0, 2'b11, 0);
    a = in_data[DW-1:0];
    b = in_data[2*DW-1:DW];
    chk("ab_count", DW'(count), 2);
    chk("ab_valid", DW'(out_valid), 3);
    chk("ab_l0", out_data[DW-1:0], a);
    chk("ab_l1", out_data[2*DW-1:DW], b);
    cyc(1, 0, 2'b10, 0);
    c = in_data[2*DW-1:DW];
    cyc(1, 0, 2'b00, 1);
    chk("c_l0", out_data[DW-1:0], b);
    chk("c_l1", out_data[2*DW-1:DW], c);
    repeat (6) cyc(1, 0, 2'b11, 0);
    cyc(1, 0, 2'b01, 0);
    chk("fill_count", DW'(count), 15);
    chk("fill_ready", DW'(in_ready), 0);
    cyc(1, 0, 2'b11, 0);
    chk("drop_count", DW'(count), 15);
    cyc(1, 0, 2'b00, 2);
    chk("pop_count", DW'(count), 13);
    chk("pop_ready", DW'(in_ready), 1);
    // move head to 15 so the next pair straddles the wrap point
    cyc(0, 0, 0, 0);
    repeat (7) cyc(1, 0, 2'b11, 0);
    cyc(1, 0, 2'b01, 0);
    repeat (7) cyc(1, 0, 2'b00, 2);
    cyc(1, 0, 2'b00, 1);
    chk("wrap_empty", DW'(empty), 1);
    cyc(1, 0, 2'b11, 0);
    chk("wrap_l0", out_data[DW-1:0], in_data[DW-1:0]);
    chk("wrap_l1", out_data[2*DW-1:DW], in_data[2*DW-1:DW]);
    repeat (40) cyc(1, 0, 2'($urandom), 2'($urandom_range(0, q.size() < 2 ? q.size() : 2)));
    cyc(0, 0, 0, 0);
    cyc(1, 0, 2'b01, 0);
    cyc(1, 0, 2'b00, 2);
    chk("err_count", DW'(count), 0);
    chk("err_set", DW'(issue_err), 1);
    cyc(1, 0, 2'b00, 0);
    chk("err_sticky", DW'(issue_err), 1);
    repeat (4) cyc(1, 0, 2'b11, 0);
    cyc(1, 0, 2'b01, 0);
    chk("pre_flush", DW'(count), 9);
    cyc(1, 1, 2'b11, 0);
    chk("flush_count", DW'(count), 0);
    chk("flush_empty", DW'(empty), 1);
    chk("flush_err", DW'(issue_err), 1);
    cyc(0, 0, 0, 0);
    chk("err_clear", DW'(issue_err), 0);
    for (int t = 0; t < 400; t++)
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 29) == 0, 2'($urandom),
          $urandom_range(0, 9) == 0 ? 2'($urandom) : 2'($urandom_range(0, q.size() < 2 ? q.size() : 2)));
    @(negedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
